// File: rtl/inst_memaccess_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states and pipeline bundles.
package inst_memaccess_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic        wr_reg;
    logic [4:0]  regindex;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        wr_mem;
    logic [31:0] memwdata;
    logic [2:0]  op;
    logic        mem_en;
    logic        load;
    logic        store;
    logic        exp;
  } ex_bundle_t;

  typedef struct packed {
    logic        wr_reg;
    logic [4:0]  regindex;
    logic [31:0] wdata;
    logic        ld;
    logic        split;
    logic [1:0]  off;
    logic [2:0]  op;
  } wb_bundle_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] op);
    case (op[1:0])
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Halfword at byte 3 or any unaligned word spills into the next RAM word.
  function automatic logic is_cross(input logic [2:0] op, input logic [1:0] off);
    is_cross = ((op[1:0] == 2'b01) && (off == 2'd3)) ||
               ((op[1:0] == 2'b10) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/inst_memaccess_load_align.sv
// Extracts the addressed bytes from a (possibly two-word) load window and extends them.
module inst_memaccess_load_align
  import inst_memaccess_pkg::*;
(
  input  logic [63:0] d64,
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  logic [31:0] sel;

  assign sel = d64[{off, 3'b000} +: 32];

  always_comb begin
    data = sel;
    case (op)
      OP_B:    data = {{24{sel[7]}}, sel[7:0]};
      OP_H:    data = {{16{sel[15]}}, sel[15:0]};
      OP_BU:   data = {24'b0, sel[7:0]};
      OP_HU:   data = {16'b0, sel[15:0]};
      default: data = sel;
    endcase
  end

endmodule

// File: rtl/inst_memaccess.sv
// RV32 MEM stage: registers the execute bundle, drives the data RAM, splits word-crossing
// accesses into two aligned beats and formats load data for write-back.
module inst_memaccess
  import inst_memaccess_pkg::*;
#(
  parameter int RAM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex2mem_wr_reg,
  input  logic [4:0]        ex2mem_wr_regindex,
  input  logic [31:0]       ex2mem_wr_wdata,
  input  logic [31:0]       ex2mem_memaddr,
  input  logic              ex2mem_wr_mem,
  input  logic [31:0]       ex2mem_wr_memwdata,
  input  logic [2:0]        ex2mem_mem_op,
  input  logic              ex2mem_mem_en,
  input  logic              ex2mem_load,
  input  logic              ex2mem_store,
  input  logic              ex2mem_exp,
  output logic              ex2mem_store_ffout,
  output logic              ex2mem_mem_en_ffout,
  output logic              mem_misaligned_exxeption,
  output logic [31:0]       mem2ex_memadr,
  output logic [2:0]        mem2ex_mem_op,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              mem2wb_wr_reg,
  output logic [4:0]        mem2wb_wr_regindex,
  output logic [31:0]       mem2wb_wr_wdata
);

  ex_bundle_t        ex_in, r_p1;
  wb_bundle_t        wb_next, r_p2;
  mem_state_e        state;
  logic [31:0]       lo_buf;
  logic              acc, split_go, in_split;
  logic [1:0]        off;
  logic [RAM_AW-1:0] wa;
  logic [7:0]        be64;
  logic [63:0]       wd64, d64;
  logic [31:0]       ld_data;

  assign ex_in = '{
    wr_reg:   ex2mem_wr_reg,
    regindex: ex2mem_wr_regindex,
    wdata:    ex2mem_wr_wdata,
    addr:     ex2mem_memaddr,
    wr_mem:   ex2mem_wr_mem,
    memwdata: ex2mem_wr_memwdata,
    op:       ex2mem_mem_op,
    mem_en:   ex2mem_mem_en,
    load:     ex2mem_load,
    store:    ex2mem_store,
    exp:      ex2mem_exp
  };

  // p1: address decode and RAM request from the registered execute bundle
  assign acc      = r_p1.mem_en & ~r_p1.exp;
  assign off      = r_p1.addr[1:0];
  assign wa       = r_p1.addr[RAM_AW+1:2];
  assign in_split = (state == ST_SPLIT);
  assign split_go = ~in_split & acc & is_cross(r_p1.op, off);
  assign be64     = {4'b0, lane_mask(r_p1.op)} << off;
  assign wd64     = {32'b0, r_p1.memwdata} << {off, 3'b000};

  assign mem_misaligned_exxeption = split_go;
  assign ex2mem_store_ffout       = r_p1.store;
  assign ex2mem_mem_en_ffout      = r_p1.mem_en;
  assign mem2ex_mem_op            = r_p1.op;
  assign mem2ex_memadr            = acc ? {r_p1.addr[31:2] + 30'd1, 2'b00} : 32'b0;

  assign ram_en    = acc;
  assign ram_we    = acc & r_p1.wr_mem;
  assign ram_addr  = in_split ? wa + RAM_AW'(1) : wa;
  assign ram_be    = acc ? (in_split ? be64[7:4] : be64[3:0]) : 4'b0;
  assign ram_wdata = in_split ? wd64[63:32] : wd64[31:0];

  assign wb_next = '{
    wr_reg:   r_p1.wr_reg,
    regindex: r_p1.regindex,
    wdata:    r_p1.wdata,
    ld:       r_p1.load & acc,
    split:    in_split,
    off:      off,
    op:       r_p1.op
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      r_p1   <= '0;
      r_p2   <= '0;
      lo_buf <= '0;
    end else begin
      if (!split_go) r_p1 <= ex_in;
      case (state)
        ST_IDLE: begin
          if (split_go) begin
            r_p2  <= '0;
            state <= ST_SPLIT;
          end else begin
            r_p2 <= wb_next;
          end
        end
        ST_SPLIT: begin
          lo_buf <= ram_rdata;
          r_p2   <= wb_next;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p2: load data returns from RAM; a split load joins it with the buffered first beat
  assign d64 = r_p2.split ? {ram_rdata, lo_buf} : {32'b0, ram_rdata};

  inst_memaccess_load_align u_align (
    .d64  (d64),
    .off  (r_p2.off),
    .op   (r_p2.op),
    .data (ld_data)
  );

  assign mem2wb_wr_reg      = r_p2.wr_reg;
  assign mem2wb_wr_regindex = r_p2.regindex;
  assign mem2wb_wr_wdata    = r_p2.ld ? ld_data : r_p2.wdata;

endmodule

// File: tb/tb_inst_memaccess.sv
// Bench for inst_memaccess: byte-addressed reference memory, write-back scoreboard, RAM model.
module tb_inst_memaccess;

  localparam int AW = 14;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex2mem_wr_reg, ex2mem_wr_mem, ex2mem_mem_en, ex2mem_load, ex2mem_store, ex2mem_exp;
  logic [4:0]    ex2mem_wr_regindex;
  logic [31:0]   ex2mem_wr_wdata, ex2mem_memaddr, ex2mem_wr_memwdata;
  logic [2:0]    ex2mem_mem_op;
  logic          ex2mem_store_ffout, ex2mem_mem_en_ffout, mem_misaligned_exxeption;
  logic [31:0]   mem2ex_memadr;
  logic [2:0]    mem2ex_mem_op;
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          mem2wb_wr_reg;
  logic [4:0]    mem2wb_wr_regindex;
  logic [31:0]   mem2wb_wr_wdata;

  inst_memaccess #(.RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .ex2mem_wr_reg(ex2mem_wr_reg), .ex2mem_wr_regindex(ex2mem_wr_regindex),
    .ex2mem_wr_wdata(ex2mem_wr_wdata), .ex2mem_memaddr(ex2mem_memaddr),
    .ex2mem_wr_mem(ex2mem_wr_mem), .ex2mem_wr_memwdata(ex2mem_wr_memwdata),
    .ex2mem_mem_op(ex2mem_mem_op), .ex2mem_mem_en(ex2mem_mem_en),
    .ex2mem_load(ex2mem_load), .ex2mem_store(ex2mem_store), .ex2mem_exp(ex2mem_exp),
    .ex2mem_store_ffout(ex2mem_store_ffout), .ex2mem_mem_en_ffout(ex2mem_mem_en_ffout),
    .mem_misaligned_exxeption(mem_misaligned_exxeption),
    .mem2ex_memadr(mem2ex_memadr), .mem2ex_mem_op(mem2ex_mem_op),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .mem2wb_wr_reg(mem2wb_wr_reg), .mem2wb_wr_regindex(mem2wb_wr_regindex),
    .mem2wb_wr_wdata(mem2wb_wr_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with byte enables
  logic [31:0] ram [NW];
  always @(posedge clk) begin
    if (ram_en && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
    if (ram_en && !ram_we) ram_rdata <= ram[ram_addr];
  end

  logic [7:0] refm [4*NW];
  typedef struct { logic [4:0] idx; logic [31:0] data; } exp_t;
  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic int nbytes(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op);
    logic [31:0] v;
    logic [15:0] a;
    v = '0;
    for (int i = 0; i < nbytes(op); i++) begin
      a = addr[15:0] + 16'(i);
      v[8*i +: 8] = refm[a];
    end
    if (op == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (op == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] d);
    logic [15:0] a;
    for (int i = 0; i < nbytes(op); i++) begin
      a = addr[15:0] + 16'(i);
      refm[a] = d[8*i +: 8];
    end
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    ram[w] = v;
    for (int i = 0; i < 4; i++) refm[4*w + i] = v[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic go_idle;
    ex2mem_wr_reg = 1'b0; ex2mem_wr_regindex = '0; ex2mem_wr_wdata = '0;
    ex2mem_memaddr = '0; ex2mem_wr_mem = 1'b0; ex2mem_wr_memwdata = '0;
    ex2mem_mem_op = '0; ex2mem_mem_en = 1'b0; ex2mem_load = 1'b0;
    ex2mem_store = 1'b0; ex2mem_exp = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and record its expected write-back
  task automatic drive(input logic ld, input logic st, input logic ex, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] idx, input logic [31:0] alu);
    exp_t e;
    ex2mem_wr_reg = !st; ex2mem_wr_regindex = idx; ex2mem_wr_wdata = alu;
    ex2mem_memaddr = addr; ex2mem_wr_mem = st; ex2mem_wr_memwdata = sdata;
    ex2mem_mem_op = op; ex2mem_mem_en = ld | st; ex2mem_load = ld;
    ex2mem_store = st; ex2mem_exp = ex;
    if (st && !ex) ref_store(addr, op, sdata);
    if (!st) begin
      e.idx  = idx;
      e.data = (ld && !ex) ? ref_load(addr, op) : alu;
      sbq.push_back(e);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic ex, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] idx, input logic [31:0] alu);
    int guard;
    drive(ld, st, ex, op, addr, sdata, idx, alu);
    guard = 0;
    @(negedge clk);
    while (mem_misaligned_exxeption && guard < 8) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 8) begin
      n_vec++; n_err++;
      $display("FAIL capture_timeout: stall still 1 after %0d cycles, required release", guard);
    end
    step();
    go_idle();
  endtask

  task automatic monitor_loop;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem2wb_wr_reg) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL wb_unexpected: got rd %0d data 0x%08h, required no write-back",
                   mem2wb_wr_regindex, mem2wb_wr_wdata);
        end else begin
          e = sbq.pop_front();
          if (mem2wb_wr_regindex !== e.idx || mem2wb_wr_wdata !== e.data) begin
            n_err++;
            $display("FAIL wb_data: got rd %0d 0x%08h, required rd %0d 0x%08h",
                     mem2wb_wr_regindex, mem2wb_wr_wdata, e.idx, e.data);
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] addr, saved;
    int          kind;
    logic [2:0]  lops [5];
    lops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    for (int w = 0; w < NW; w++) poke(w, $urandom);
    go_idle();
    rst = 1'b1;
    fork monitor_loop(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_be", 32'(ram_be), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_stall", 32'(mem_misaligned_exxeption), 32'h0);
    chk("rst_memadr", mem2ex_memadr, 32'h0);
    chk("rst_wb", {26'(mem2wb_wr_regindex), 5'(mem2ex_mem_op), mem2wb_wr_reg}, 32'h0);
    chk("rst_wb_data", mem2wb_wr_wdata, 32'h0);
    chk("rst_ffout", {30'(ex2mem_store_ffout), ex2mem_mem_en_ffout, 1'b0}, 32'h0);
    rst = 1'b0;
    step();

    // Aligned LW
    poke(32'h40, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'h0);
    step(); go_idle();
    chk("lw_ram_en", 32'(ram_en), 32'h1);
    chk("lw_ram_we", 32'(ram_we), 32'h0);
    chk("lw_ram_addr", 32'(ram_addr), 32'h40);
    chk("lw_ram_be", 32'(ram_be), 32'hF);
    chk("lw_stall", 32'(mem_misaligned_exxeption), 32'h0);
    step();
    chk("lw_wb_reg", 32'(mem2wb_wr_reg), 32'h1);
    chk("lw_wb_data", mem2wb_wr_wdata, 32'hDEADBEEF);

    // LB / LBU of the top byte, back to back
    poke(32'h40, 32'h80112233);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 32'h0);
    step();
    chk("lb_ram_be", 32'(ram_be), 32'h8);
    drive(1'b1, 1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h0);
    step(); go_idle();
    chk("lbu_ram_be", 32'(ram_be), 32'h8);
    chk("lb_wb_data", mem2wb_wr_wdata, 32'hFFFFFF80);
    step();
    chk("lbu_wb_data", mem2wb_wr_wdata, 32'h00000080);

    // Word-crossing LW
    poke(32'h41, 32'h44332211);
    poke(32'h42, 32'h88776655);
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h105, 32'h0, 5'd8, 32'h0);
    step(); go_idle();
    chk("xlw_stall1", 32'(mem_misaligned_exxeption), 32'h1);
    chk("xlw_addr1", 32'(ram_addr), 32'h41);
    chk("xlw_be1", 32'(ram_be), 32'hE);
    chk("xlw_memadr", mem2ex_memadr, 32'h108);
    chk("xlw_mem_op", 32'(mem2ex_mem_op), 32'h2);
    chk("xlw_flags", {30'(ex2mem_mem_en_ffout), ex2mem_store_ffout, mem2wb_wr_reg}, 32'h4);
    step();
    chk("xlw_stall2", 32'(mem_misaligned_exxeption), 32'h0);
    chk("xlw_addr2", 32'(ram_addr), 32'h42);
    chk("xlw_be2", 32'(ram_be), 32'h1);
    chk("xlw_bubble", 32'(mem2wb_wr_reg), 32'h0);
    step();
    chk("xlw_wb_reg", 32'(mem2wb_wr_reg), 32'h1);
    chk("xlw_wb_data", mem2wb_wr_wdata, 32'h55443322);

    // Word-crossing SH
    drive(1'b0, 1'b1, 1'b0, 3'b001, 32'h3, 32'h0000ABCD, 5'd0, 32'h0);
    step(); go_idle();
    chk("xsh_we1", {30'(ram_we), ex2mem_store_ffout, mem_misaligned_exxeption}, 32'h7);
    chk("xsh_addr1", 32'(ram_addr), 32'h0);
    chk("xsh_be1", 32'(ram_be), 32'h8);
    chk("xsh_wd1", ram_wdata, 32'hCD000000);
    step();
    chk("xsh_we2", 32'(ram_we), 32'h1);
    chk("xsh_addr2", 32'(ram_addr), 32'h1);
    chk("xsh_be2", 32'(ram_be), 32'h1);
    chk("xsh_wd2", ram_wdata, 32'h000000AB);
    step();

    // Excepting load: no RAM access, no split, ALU value passed through
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h105, 32'h0, 5'd9, 32'h12345678);
    step(); go_idle();
    chk("exp_ram_en", 32'(ram_en), 32'h0);
    chk("exp_stall", 32'(mem_misaligned_exxeption), 32'h0);
    step();
    chk("exp_wb_data", mem2wb_wr_wdata, 32'h12345678);

    // Randomized traffic against the byte-level reference memory
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[15:6] = '0;
      if ($urandom_range(0, 7) == 0) addr[15:4] = 12'hFFF;
      if (kind <= 3) begin
        op = lops[$urandom_range(0, 4)];
        issue(1'b1, 1'b0, ($urandom_range(0, 15) == 0), op, addr, $urandom,
              5'($urandom), $urandom);
      end else if (kind <= 6) begin
        op = 3'($urandom_range(0, 2));
        issue(1'b0, 1'b1, ($urandom_range(0, 15) == 0), op, addr, $urandom,
              5'($urandom), $urandom);
      end else begin
        issue(1'b0, 1'b0, 1'b0, 3'($urandom), addr, $urandom, 5'($urandom), $urandom);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end
    repeat (4) step();
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    // SW at the very top of RAM: beat 2 wraps to word 0
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000FFFE, 32'h11223344, 5'd0, 32'h0);
    step(); go_idle();
    chk("wrap_addr1", 32'(ram_addr), 32'h3FFF);
    chk("wrap_be1", 32'(ram_be), 32'hC);
    chk("wrap_wd1", ram_wdata, 32'h33440000);
    step();
    chk("wrap_addr2", 32'(ram_addr), 32'h0);
    chk("wrap_be2", 32'(ram_be), 32'h3);
    chk("wrap_wd2", ram_wdata, 32'h00001122);
    step();

    // Reset while in the second beat of a split store
    saved = ram[32'h83];
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h20A, ~saved, 5'd0, 32'h0);
    step(); go_idle();
    chk("rsplit_stall", 32'(mem_misaligned_exxeption), 32'h1);
    step();
    chk("rsplit_beat2", 32'(ram_addr), 32'h83);
    rst = 1'b1;
    #1;
    chk("rsplit_strobes", {30'(ram_en), ram_we, mem_misaligned_exxeption}, 32'h0);
    chk("rsplit_be", 32'(ram_be), 32'h0);
    step();
    chk("rsplit_no_beat2", ram[32'h83], saved);
    rst = 1'b0;
    step();
    chk("rsplit_idle", {30'(ram_en), mem_misaligned_exxeption, mem2wb_wr_reg}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
